// File: rtl/ahbl_master_stage.sv
`timescale 1ns/1ps
// Per-master AHB-Lite front end: decodes the address phase into a one-hot slave request,
// parks the address phase while the target arbiter withholds grant, and steers the response back.
module ahbl_master_stage #(
    parameter logic [3:0] SLAVE_EN = 4'b1111,
    parameter logic [1:0] MAP_TOP  = 2'b00
) (
    input  logic         i_hclk,
    input  logic         i_hreset,
    input  logic [31:0]  i_haddr,
    input  logic [1:0]   i_htrans,
    input  logic         i_hwrite,
    input  logic [2:0]   i_hsize,
    input  logic [2:0]   i_hburst,
    input  logic [3:0]   i_hprot,
    input  logic         i_hmastlock,
    output logic         o_hready_m,
    output logic         o_hresp_m,
    output logic [31:0]  o_hrdata_m,
    output logic [3:0]   o_req,
    output logic         o_lock_out,
    input  logic [3:0]   i_grant,
    output logic [31:0]  o_saddr,
    output logic [1:0]   o_strans,
    output logic         o_swrite,
    output logic [2:0]   o_ssize,
    output logic [2:0]   o_sburst,
    output logic [3:0]   o_sprot,
    input  logic [3:0]   i_s_hreadyout,
    input  logic [3:0]   i_s_hresp,
    input  logic [127:0] i_s_hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ds;
    logic [1:0]  w_ds_nxt;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [2:0]  r_hburst;
    logic [3:0]  r_hprot;
    logic        r_hmastlock;

    logic [1:0]  w_live_slot;
    logic [1:0]  w_held_slot;
    logic        w_mapped;
    logic        w_vt;
    logic        w_sel_hold;
    logic [31:0] w_slot_rdata;
    logic        w_capture;
    state_t      w_acc_state;
    logic [1:0]  w_acc_ds;
    logic        w_acc_capture;

    assign w_live_slot = i_haddr[29:28];
    assign w_held_slot = r_haddr[29:28];
    assign w_mapped    = (i_haddr[31:30] == MAP_TOP) && SLAVE_EN[w_live_slot];
    assign w_vt        = i_htrans[1] & o_hready_m;

    // Read-data lane of the slave owning the current data phase.
    always_comb begin
        w_slot_rdata = 32'h0000_0000;
        case (r_ds)
            2'd0:    w_slot_rdata = i_s_hrdata[31:0];
            2'd1:    w_slot_rdata = i_s_hrdata[63:32];
            2'd2:    w_slot_rdata = i_s_hrdata[95:64];
            2'd3:    w_slot_rdata = i_s_hrdata[127:96];
            default: w_slot_rdata = 32'h0000_0000;
        endcase
    end

    // Master-side response: the data phase passes the owning slave straight through.
    always_comb begin
        o_hready_m = 1'b1;
        o_hresp_m  = 1'b0;
        o_hrdata_m = 32'h0000_0000;
        w_sel_hold = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_hready_m = 1'b1;
            end
            ST_PEND: begin
                o_hready_m = 1'b0;
                w_sel_hold = 1'b1;
            end
            ST_DATA: begin
                o_hready_m = i_s_hreadyout[r_ds];
                o_hresp_m  = i_s_hresp[r_ds];
                o_hrdata_m = w_slot_rdata;
            end
            ST_ERR1: begin
                o_hready_m = 1'b0;
                o_hresp_m  = 1'b1;
            end
            ST_ERR2: begin
                o_hready_m = 1'b1;
                o_hresp_m  = 1'b1;
            end
            default: begin
                o_hready_m = 1'b1;
            end
        endcase
    end

    // Request, lock and slave-facing address phase: held copy while parked, live otherwise.
    always_comb begin
        o_req      = 4'b0000;
        o_lock_out = 1'b0;
        o_saddr    = i_haddr;
        o_strans   = i_htrans;
        o_swrite   = i_hwrite;
        o_ssize    = i_hsize;
        o_sburst   = i_hburst;
        o_sprot    = i_hprot;
        if (w_sel_hold) begin
            o_req      = onehot4(w_held_slot);
            o_lock_out = r_hmastlock;
            o_saddr    = r_haddr;
            o_strans   = r_htrans;
            o_swrite   = r_hwrite;
            o_ssize    = r_hsize;
            o_sburst   = r_hburst;
            o_sprot    = r_hprot;
        end else if (w_vt && w_mapped) begin
            o_req      = onehot4(w_live_slot);
            o_lock_out = i_hmastlock;
        end else begin
            o_req      = 4'b0000;
            o_lock_out = 1'b0;
        end
    end

    // Outcome of accepting a new address phase (shared by IDLE, DATA completion and ERR2).
    always_comb begin
        w_acc_state   = ST_IDLE;
        w_acc_ds      = r_ds;
        w_acc_capture = 1'b0;
        if (w_vt) begin
            if (w_mapped) begin
                if (i_grant[w_live_slot]) begin
                    w_acc_state = ST_DATA;
                    w_acc_ds    = w_live_slot;
                end else begin
                    w_acc_state   = ST_PEND;
                    w_acc_capture = 1'b1;
                end
            end else begin
                w_acc_state = ST_ERR1;
            end
        end else begin
            w_acc_state = ST_IDLE;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        w_ds_nxt    = r_ds;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nxt = w_acc_state;
                w_ds_nxt    = w_acc_ds;
                w_capture   = w_acc_capture;
            end
            ST_PEND: begin
                if (i_grant[w_held_slot]) begin
                    w_state_nxt = ST_DATA;
                    w_ds_nxt    = w_held_slot;
                end else begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_DATA: begin
                if (i_s_hreadyout[r_ds]) begin
                    w_state_nxt = w_acc_state;
                    w_ds_nxt    = w_acc_ds;
                    w_capture   = w_acc_capture;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and data-slot registers.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state <= ST_IDLE;
            r_ds    <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ds    <= w_ds_nxt;
        end
    end

    // Hold registers: loaded only for a mapped phase that lost arbitration.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_haddr     <= 32'h0000_0000;
            r_htrans    <= 2'b00;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'b000;
            r_hburst    <= 3'b000;
            r_hprot     <= 4'b0000;
            r_hmastlock <= 1'b0;
        end else if (w_capture) begin
            r_haddr     <= i_haddr;
            r_htrans    <= i_htrans;
            r_hwrite    <= i_hwrite;
            r_hsize     <= i_hsize;
            r_hburst    <= i_hburst;
            r_hprot     <= i_hprot;
            r_hmastlock <= i_hmastlock;
        end
    end

endmodule

// File: doc/ahbl_master_stage.md
Name: ahbl_master_stage

Overview:
Per-master front end of the AHB-Lite matrix. It sits directly upstream of the per-slave round-robin arbiters. It decodes one master's address phase into a one-hot request for 4 slave slots, and holds the address/control while the target arbiter withholds its grant. It then steers the granted slave's HREADYOUT/HRESP/HRDATA back to the master. Unmapped or disabled addresses go to an internal default slave that returns a two-cycle ERROR.

Parameters:
SLAVE_EN, 4'b1111, per-slot enable mask; a disabled slot decodes as unmapped.
MAP_TOP, 2'b00, required value of HADDR[31:30] for a mapped access; slot index = HADDR[29:28].

Ports:
HCLK  in  1  clock; all logic is on the rising edge.
HRESET  in  1  reset; one clock, reset is synchronous and active-high.
HADDR  in  32  master address.
HTRANS  in  2  master transfer type (IDLE/BUSY/NONSEQ/SEQ).
HWRITE  in  1  master write.
HSIZE  in  3  master size.
HBURST  in  3  master burst.
HPROT  in  4  master protection.
HMASTLOCK  in  1  master lock.
HREADY_M  out  1  ready to master.
HRESP_M  out  1  response to master.
HRDATA_M  out  32  read data to master.
REQ  out  4  one-hot slave request, feeds the slave arbiter request input for this master.
LOCK_OUT  out  1  lock qualifier to the arbiters.
GRANT  in  4  bit s = slave arbiter s grants this master (combinational from the arbiter).
SADDR/STRANS/SWRITE/SSIZE/SBURST/SPROT  out  32/2/1/3/3/4  address phase presented to the slave muxes.
S_HREADYOUT  in  4  per-slave ready.
S_HRESP  in  4  per-slave response.
S_HRDATA  in  128  per-slave read data; slot s occupies bits [32s+31:32s].

Behaviour:
- Valid transfer (vt): HTRANS[1]=1 and HREADY_M=1. Mapped when HADDR[31:30]==MAP_TOP and SLAVE_EN[slot]=1.
- States: IDLE, PEND, DATA, ERR1, ERR2. Data-slot register ds[1:0].
- Live/held select: when sel_hold=1, S* outputs and REQ are driven from the hold registers; otherwise from the live inputs.
- sel_hold=1 only in PEND.
- REQ:
  - onehot(slot) when vt and mapped; onehot(held slot) in PEND; else 0.
  - LOCK_OUT = live or held HMASTLOCK, same selection as REQ.
- IDLE (also the post-completion cycle of DATA):
  - vt, mapped, GRANT[slot]=1 -> DATA, ds<=slot.
  - vt, mapped, GRANT[slot]=0 -> capture address/control/lock into hold registers -> PEND.
  - vt, unmapped -> ERR1.
  - No vt -> IDLE.
  - HREADY_M=1, HRESP_M=0.
- PEND:
  - HREADY_M=0, HRESP_M=0.
  - Live inputs are ignored because the master is stalled.
  - GRANT[held slot]=1 -> DATA, ds<=held slot. Otherwise remain in PEND.
- DATA:
  - HREADY_M=S_HREADYOUT[ds], HRESP_M=S_HRESP[ds], HRDATA_M=S_HRDATA slot ds.
  - S_HREADYOUT[ds]=1 completes the transfer. In that cycle vt is evaluated exactly as in IDLE (pipelined next address), including PEND/ERR1 entry.
  - Otherwise remain in DATA; hold registers and REQ are unaffected.
- ERR1: HREADY_M=0, HRESP_M=1 -> ERR2.
- ERR2: HREADY_M=1, HRESP_M=1. vt in this cycle is accepted as in IDLE; otherwise -> IDLE.
- HRDATA_M=0 outside DATA.
- IDLE/BUSY HTRANS to any address: zero-wait OKAY, no REQ.
- Reset:
  - state IDLE, ds=0, hold registers 0.
  - Outputs: HREADY_M=1, HRESP_M=0, REQ=0, LOCK_OUT=0, HRDATA_M=0, S* = live inputs.
  - Asserting HRESET mid-transfer abandons it; no ERROR is issued.
- Slave ERROR (two-cycle) is passed through unchanged from S_HRESP/S_HREADYOUT.
- Out-of-range held slot cannot occur, because the hold registers are only loaded for mapped slots.

Test Plan:
- Mapped read, granted immediately: HADDR=0x1000_0004 NONSEQ read, GRANT=4'b0010 -> REQ=4'b0010 in the address cycle. Next cycle DATA with S_HRDATA slot1=0xCAFE_0001 and S_HREADYOUT[1]=1 -> HRDATA_M=0xCAFE_0001, HREADY_M=1.
- Grant withheld:
  - NONSEQ write to 0x2000_0000 with GRANT=0 for 3 cycles -> PEND, HREADY_M=0, REQ=4'b0100, SADDR=0x2000_0000 held while HADDR changes.
  - GRANT[2]=1 -> DATA the next cycle.
- Unmapped access: NONSEQ to 0x8000_0000 -> HREADY_M=0/HRESP_M=1, then HREADY_M=1/HRESP_M=1, REQ never asserted.
- Disabled slot: SLAVE_EN=4'b0111, NONSEQ to 0x3000_0000 -> same two-cycle ERROR.
- Pipelined, with wait state:
  - Slot0 data phase with S_HREADYOUT[0]=0 for 2 cycles -> HREADY_M=0.
  - On completion, the next NONSEQ to slot3 with GRANT[3]=1 -> ds=3 without an IDLE gap.
- Reset in PEND: assert HRESET one cycle -> next cycle IDLE, HREADY_M=1, REQ=0, hold registers 0.
